// File: rtl/maze_player_ctrl_if.sv
// maze_player_ctrl_if: shared map-wall ROM lookup port.
// master = requester (player controller), slave = ROM side.
// map_wall is valid the cycle after map_rd_en.
interface maze_player_ctrl_if;
  logic       map_rd_en;
  logic [5:0] map_rd_x;
  logic [5:0] map_rd_y;
  logic       map_wall;

  modport master (output map_rd_en, output map_rd_x, output map_rd_y, input map_wall);
  modport slave  (input map_rd_en, input map_rd_x, input map_rd_y, output map_wall);
endinterface

// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: game sequencer and player-movement controller.
// Owns the game state, the 4x4 player position on the 40x40 grid and the
// per-stage countdown; validates moves by probing the four leading-edge
// cells through the shared map-wall ROM port.
// Optional feature macro: STEP_CNT_EN (successful-move counter on step_cnt).
module maze_player_ctrl #(
  parameter int MAP_W      = 40,
  parameter int MAP_H      = 40,
  parameter int PLAYER_SZ  = 4,
  parameter int START_X    = 0,
  parameter int START_Y    = 18,
  parameter int EXIT_X     = 36,
  parameter int TIME_LIMIT = 60
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btn_start,
  input  logic                       btn_staff,
  input  logic [3:0]                 move_req,
  input  logic                       tick_1hz,
  maze_player_ctrl_if.master         map,
  output logic [1:0]                 map_sel,
  output logic [3:0]                 state,
  output logic [5:0]                 player_x,
  output logic [5:0]                 player_y,
  output logic [6:0]                 time_left,
  output logic                       busy,
  output logic [9:0]                 step_cnt
);

  typedef enum logic [3:0] {
    TITLE = 4'd0, STAFF = 4'd1, STAGE1 = 4'd2, SUCCESS1 = 4'd3, STAGE2 = 4'd4,
    SUCCESS2 = 4'd5, STAGE3 = 4'd6, SUCCESS3 = 4'd7, FAIL = 4'd8
  } game_t;

  typedef enum logic [1:0] {IDLE, PROBE, COMMIT, CHECK} mover_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  game_t      r_game, w_game_nxt;
  mover_t     r_mover, w_mover_nxt;
  dir_t       r_dir, w_dir_sel;
  logic [1:0] r_k;
  logic       r_hit;
  logic [5:0] r_px, r_py;
  logic [6:0] r_time;
  logic [1:0] r_map_sel;
  logic       w_in_stage, w_enter, w_abort, w_accept, w_commit, w_oob;
  logic [6:0] w_x_far, w_y_far;

  assign w_in_stage = (r_game == STAGE1) || (r_game == STAGE2) || (r_game == STAGE3);
  assign w_enter    = (w_game_nxt != r_game) &&
                      ((w_game_nxt == STAGE1) || (w_game_nxt == STAGE2) || (w_game_nxt == STAGE3));
  // Any game transition out of a stage kills an in-flight move.
  assign w_abort    = (w_game_nxt != r_game);
  assign w_x_far    = {1'b0, r_px} + 7'(PLAYER_SZ);
  assign w_y_far    = {1'b0, r_py} + 7'(PLAYER_SZ);

  // Game sequencer next state (exit has priority over timeout).
  always_comb begin
    w_game_nxt = r_game;
    case (r_game)
      TITLE:    if (btn_start) w_game_nxt = STAGE1;
                else if (btn_staff) w_game_nxt = STAFF;
      STAFF:    if (btn_start) w_game_nxt = TITLE;
      STAGE1:   if (r_px == 6'(EXIT_X)) w_game_nxt = SUCCESS1;
                else if (r_time == '0) w_game_nxt = FAIL;
      STAGE2:   if (r_px == 6'(EXIT_X)) w_game_nxt = SUCCESS2;
                else if (r_time == '0) w_game_nxt = FAIL;
      STAGE3:   if (r_px == 6'(EXIT_X)) w_game_nxt = SUCCESS3;
                else if (r_time == '0) w_game_nxt = FAIL;
      SUCCESS1: if (btn_start) w_game_nxt = STAGE2;
      SUCCESS2: if (btn_start) w_game_nxt = STAGE3;
      SUCCESS3: if (btn_start) w_game_nxt = TITLE;
      FAIL:     if (btn_start) w_game_nxt = TITLE;
      default:  w_game_nxt = TITLE;
    endcase
  end

  // Request direction priority and bounds check on the current position.
  always_comb begin
    w_dir_sel = D_RIGHT;
    if (move_req[3])      w_dir_sel = D_UP;
    else if (move_req[2]) w_dir_sel = D_DOWN;
    else if (move_req[1]) w_dir_sel = D_LEFT;
    w_oob = 1'b0;
    case (w_dir_sel)
      D_UP:    w_oob = (r_py == '0);
      D_DOWN:  w_oob = (w_y_far >= 7'(MAP_H));
      D_LEFT:  w_oob = (r_px == '0);
      D_RIGHT: w_oob = (w_x_far >= 7'(MAP_W));
      default: w_oob = 1'b0;
    endcase
  end

  // Mover next state: PROBE issues 4 lookups, COMMIT takes the last wall bit,
  // CHECK is the single busy cycle of an out-of-bounds rejection.
  always_comb begin
    w_mover_nxt = r_mover;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_mover)
      IDLE: if (w_in_stage && (move_req != '0)) begin
              w_accept    = 1'b1;
              w_mover_nxt = w_oob ? CHECK : PROBE;
            end
      PROBE:  if (r_k == 2'd3) w_mover_nxt = COMMIT;
      COMMIT: begin
                w_commit    = !(r_hit || map.map_wall);
                w_mover_nxt = IDLE;
              end
      CHECK:  w_mover_nxt = IDLE;
      default: w_mover_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_mover_nxt = IDLE;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
    end
  end

  // Game state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_game <= TITLE;
    else        r_game <= w_game_nxt;
  end

  // Mover state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mover <= IDLE;
    else        r_mover <= w_mover_nxt;
  end

  // Position, timer, map select and probe bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px      <= 6'(START_X);
      r_py      <= 6'(START_Y);
      r_time    <= 7'(TIME_LIMIT);
      r_map_sel <= '0;
      r_dir     <= D_UP;
      r_k       <= '0;
      r_hit     <= 1'b0;
    end else begin
      if (w_enter) begin
        r_px      <= 6'(START_X);
        r_py      <= 6'(START_Y);
        r_time    <= 7'(TIME_LIMIT);
        r_map_sel <= (w_game_nxt == STAGE1) ? 2'd0 : (w_game_nxt == STAGE2) ? 2'd1 : 2'd2;
      end else begin
        if (w_commit) begin
          case (r_dir)
            D_UP:    r_py <= r_py - 6'd1;
            D_DOWN:  r_py <= r_py + 6'd1;
            D_LEFT:  r_px <= r_px - 6'd1;
            default: r_px <= r_px + 6'd1;
          endcase
        end
        if (w_in_stage && tick_1hz && (r_time != '0)) r_time <= r_time - 7'd1;
      end
      if (w_accept) begin
        r_dir <= w_dir_sel;
        r_k   <= '0;
        r_hit <= 1'b0;
      end else if (r_mover == PROBE) begin
        // wall data lags the strobe by one cycle, so lookup k-1 lands while k is issued
        r_k   <= r_k + 2'd1;
        r_hit <= r_hit || ((r_k != '0) && map.map_wall);
      end
    end
  end

  // Leading-edge lookup address for the current probe index.
  always_comb begin
    map.map_rd_en = (r_mover == PROBE);
    map.map_rd_x  = '0;
    map.map_rd_y  = '0;
    if (r_mover == PROBE) begin
      case (r_dir)
        D_UP:    begin map.map_rd_x = r_px + {4'd0, r_k}; map.map_rd_y = r_py - 6'd1; end
        D_DOWN:  begin map.map_rd_x = r_px + {4'd0, r_k}; map.map_rd_y = w_y_far[5:0]; end
        D_LEFT:  begin map.map_rd_x = r_px - 6'd1;        map.map_rd_y = r_py + {4'd0, r_k}; end
        default: begin map.map_rd_x = w_x_far[5:0];       map.map_rd_y = r_py + {4'd0, r_k}; end
      endcase
    end
  end

`ifdef STEP_CNT_EN
  logic [9:0] r_steps;

  // Successful-move counter, saturating, cleared on stage entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_steps <= '0;
    else if (w_enter)                   r_steps <= '0;
    else if (w_commit && r_steps != '1) r_steps <= r_steps + 10'd1;
  end

  assign step_cnt = r_steps;
`else
  assign step_cnt = '0;
`endif

  assign state     = r_game;
  assign player_x  = r_px;
  assign player_y  = r_py;
  assign time_left = r_time;
  assign map_sel   = r_map_sel;
  assign busy      = (r_mover != IDLE);

endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: directed test of maze_player_ctrl with a one-cell wall ROM model.
module tb_maze_player_ctrl;

`ifdef STEP_CNT_EN
  localparam int STEP_ON = 1;
`else
  localparam int STEP_ON = 0;
`endif

  logic       clk, rst_n, btn_start, btn_staff, tick_1hz;
  logic [3:0] move_req;
  logic [1:0] map_sel;
  logic [3:0] state;
  logic [5:0] player_x, player_y;
  logic [6:0] time_left;
  logic       busy;
  logic [9:0] step_cnt;

  logic       wall_en;
  logic [5:0] wall_x, wall_y;
  int         n_total = 0;
  int         n_bad   = 0;

  maze_player_ctrl_if m_if ();

  maze_player_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_staff (btn_staff),
    .move_req  (move_req),
    .tick_1hz  (tick_1hz),
    .map       (m_if.master),
    .map_sel   (map_sel),
    .state     (state),
    .player_x  (player_x),
    .player_y  (player_y),
    .time_left (time_left),
    .busy      (busy),
    .step_cnt  (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: a single wall cell, answer registered one cycle after the strobe
  always @(posedge clk)
    m_if.map_wall <= m_if.map_rd_en && wall_en && (m_if.map_rd_x == wall_x) && (m_if.map_rd_y == wall_y);

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // request in cycle 0, return positioned in cycle 6
  task automatic move(input logic [3:0] req);
    move_req = req;
    cyc();
    move_req = '0;
    repeat (5) cyc();
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn_start = 1'b0; btn_staff = 1'b0; tick_1hz = 1'b0; move_req = '0;
    wall_en = 1'b0; wall_x = '0; wall_y = '0;
    repeat (3) cyc();
    check("rst_state", state, 0);
    check("rst_px", player_x, 0);
    check("rst_py", player_y, 18);
    check("rst_time", time_left, 60);
    check("rst_busy", busy, 0);
    check("rst_rden", m_if.map_rd_en, 0);
    check("rst_sel", map_sel, 0);
    check("rst_step", step_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // both buttons: start wins
    btn_staff = 1'b1;
    press_start();
    btn_staff = 1'b0;
    check("enter_state", state, 2);
    check("enter_sel", map_sel, 0);
    check("enter_px", player_x, 0);
    check("enter_py", player_y, 18);
    check("enter_time", time_left, 60);

    // free right move, cycle-accurate
    move_req = 4'b0001;
    cyc();
    move_req = '0;
    for (int k = 0; k < 4; k++) begin
      check("mv1_rden", m_if.map_rd_en, 1);
      check("mv1_rdx", m_if.map_rd_x, 4);
      check("mv1_rdy", m_if.map_rd_y, 18 + k);
      check("mv1_busy", busy, 1);
      cyc();
    end
    check("mv1_c5_rden", m_if.map_rd_en, 0);
    check("mv1_c5_busy", busy, 1);
    check("mv1_c5_px", player_x, 0);
    cyc();
    check("mv1_c6_busy", busy, 0);
    check("mv1_c6_px", player_x, 1);
    check("mv1_c6_step", step_cnt, STEP_ON * 1);

    // wall on third lookup (5,20)
    wall_en = 1'b1; wall_x = 6'd5; wall_y = 6'd20;
    move(4'b0001);
    wall_en = 1'b0;
    check("wall_busy", busy, 0);
    check("wall_px", player_x, 1);
    check("wall_step", step_cnt, STEP_ON * 1);

    move(4'b0010);
    check("left_px", player_x, 0);

    // out-of-bounds left at x=0
    move_req = 4'b0010;
    cyc();
    move_req = '0;
    check("oob_c1_busy", busy, 1);
    check("oob_c1_rden", m_if.map_rd_en, 0);
    cyc();
    check("oob_c2_busy", busy, 0);
    check("oob_c2_rden", m_if.map_rd_en, 0);
    check("oob_px", player_x, 0);

    // up beats right
    move_req = 4'b1001;
    cyc();
    move_req = '0;
    check("prio_rdx", m_if.map_rd_x, 0);
    check("prio_rdy", m_if.map_rd_y, 17);
    repeat (5) cyc();
    check("prio_py", player_y, 17);
    check("prio_px", player_x, 0);
    move(4'b0100);
    check("down_py", player_y, 18);

    for (int i = 0; i < 35; i++) move(4'b0001);
    check("walk_px", player_x, 35);
    check("walk_step", step_cnt, STEP_ON * 39);
    move(4'b0001);
    check("exit_px", player_x, 36);
    check("exit_state_c6", state, 2);
    check("exit_step", step_cnt, STEP_ON * 40);
    cyc();
    check("exit_state_c7", state, 3);

    // move requests dropped outside stages
    move_req = 4'b0010;
    cyc();
    move_req = '0;
    check("succ_busy", busy, 0);
    check("succ_px", player_x, 36);

    press_start();
    check("s2_state", state, 4);
    check("s2_px", player_x, 0);
    check("s2_py", player_y, 18);
    check("s2_time", time_left, 60);
    check("s2_sel", map_sel, 1);
    check("s2_step", step_cnt, 0);

    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    check("tick1_time", time_left, 59);
    repeat (58) begin
      tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    end
    check("tick59_time", time_left, 1);

    // timeout arrives mid-move: move aborted
    move_req = 4'b0001;
    cyc();
    move_req = '0;
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    check("to_time", time_left, 0);
    check("to_state_c2", state, 4);
    check("to_busy_c2", busy, 1);
    cyc();
    check("to_state_c3", state, 8);
    check("to_busy_c3", busy, 0);
    repeat (3) cyc();
    check("to_px", player_x, 0);

    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0; cyc();
    check("fail_time", time_left, 0);
    check("fail_state", state, 8);
    press_start();
    check("title_state", state, 0);
    check("title_time", time_left, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_player_ctrl.md
Name: maze_player_ctrl

Overview:
- Game sequencer and player-movement controller for the maze stages.
- Owns the top-level game state (TITLE…FAIL) and the player position on the 40x40 map grid, with a 4x4-cell player.
- Validates each move request by issuing sequential lookups to the shared map-wall ROM port. Drives state and player position to the VGA drawing logic.

Parameters:
- MAP_W, 40, map width in cells
- MAP_H, 40, map height in cells
- PLAYER_SZ, 4, player footprint edge in cells
- START_X, 0, player x on stage entry
- START_Y, 18, player y on stage entry
- EXIT_X, 36, player x that completes a stage
- TIME_LIMIT, 60, seconds allowed per stage

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_start  input  1  one-cycle pulse, debounced
- btn_staff  input  1  one-cycle pulse, debounced
- move_req  input  4  one-cycle pulses {up,down,left,right}
- tick_1hz  input  1  one-cycle pulse per second
- map_wall  input  1  ROM data, valid the cycle after map_rd_en
- map_rd_en  output  1  ROM lookup strobe
- map_rd_x  output  6  lookup column
- map_rd_y  output  6  lookup row
- map_sel  output  2  stage map select: 0 = stage1, 1 = stage2, 2 = stage3
- state  output  4  TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8
- player_x  output  6  player top-left column
- player_y  output  6  player top-left row
- time_left  output  7  seconds remaining
- busy  output  1  move in progress
- step_cnt  output  10  accepted successful moves

Behaviour:
- Reset values:
  - state = TITLE
  - player_x = START_X, player_y = START_Y
  - time_left = TIME_LIMIT
  - busy, map_rd_en, map_rd_x, map_rd_y, map_sel, step_cnt = 0
  - mover FSM = IDLE
- Reset asserted mid-move aborts the move with no position change.
- Game FSM transitions:
  - TITLE: btn_start → STAGE1; btn_staff → STAFF; btn_start wins if both pulse.
  - STAFF: btn_start → TITLE.
  - STAGEn: exit → SUCCESSn; timeout → FAIL.
  - SUCCESS1/SUCCESS2: btn_start → STAGE2/STAGE3.
  - SUCCESS3: btn_start → TITLE.
  - FAIL: btn_start → TITLE.
- On every STAGEn entry:
  - player reset to START_X/START_Y
  - time_left = TIME_LIMIT
  - step_cnt = 0
  - map_sel = n-1, held until the next stage entry
- Timer:
  - Decrements on tick_1hz only in STAGE states; frozen elsewhere; saturates at 0.
  - Timeout: state goes to FAIL the cycle after time_left becomes 0.
- Mover FSM: IDLE, PROBE, CHECK, COMMIT.
  - Requests are sampled only in IDLE and only in STAGE states; all others are dropped (no queue).
  - Multiple direction bits set: priority up > down > left > right.
- Leading edge probed for direction d, k = 0..3:
  - right: (x+4, y+k)
  - left: (x-1, y+k)
  - down: (x+k, y+4)
  - up: (x+k, y-1)
- Out-of-bounds edge (x=0 left, y=0 up, x+4≥MAP_W right, y+4≥MAP_H down):
  - blocked with no lookups
  - busy high one cycle (cycle 1) only
- Normal move timing (request in cycle 0):
  - map_rd_en high in cycles 1–4, one cell per cycle in k order.
  - map_wall sampled in cycles 2–5 and OR-accumulated.
  - New position visible in cycle 6 if no wall was hit; unchanged otherwise.
  - busy high in cycles 1–5 and low in cycle 6, so a new request is accepted in cycle 6.
- Exit: committed player_x == EXIT_X → SUCCESSn in the following cycle.
- Exit and timeout in the same cycle: SUCCESS wins.
- Leaving a STAGE state mid-move (timeout) aborts the move: no commit, mover returns to IDLE.
- Widths: coordinates are 6-bit unsigned; ±1 arithmetic is computed only after the bounds check, so no wrap is possible.

Optional Feature:
- Macro: STEP_CNT_EN.
- Defined:
  - step_cnt increments on each successful commit.
  - Saturates at 1023.
  - Cleared on stage entry.
- Undefined: step_cnt tied to 0 and no counter logic is generated.

Test Plan:
- Reset, btn_start → state 2, map_sel 0, player (0,18), time_left 60.
- In STAGE1, move_req=0001 with map_wall always 0:
  - map_rd_en cycles 1–4 at (4,18..21)
  - player_x=1 in cycle 6
  - busy low in cycle 6
  - step_cnt=1 with STEP_CNT_EN
- Right move with map_wall=1 on the third lookup → player unchanged, busy low in cycle 6, step_cnt unchanged.
- Player at (0,18), move_req=0010 → no map_rd_en, busy high exactly one cycle, player unchanged.
- Player at (35,18), right move into free cells → player_x=36 then state 3; btn_start → state 4, player (0,18), time_left 60.
- In STAGE2, 60 tick_1hz pulses with no moves → time_left 0 then state 8; tick pulses ignored in FAIL; btn_start → state 0.
